// File: rtl/can_regs_pkg.sv
// Register map, command bit positions and bus-FSM state encoding shared by
// the CAN Wishbone responder and its interrupt controller.
// Ports: none (package only).
package can_regs_pkg;

   localparam logic [7:0] MODE_A   = 8'h00;
   localparam logic [7:0] CMD_A    = 8'h01;
   localparam logic [7:0] STATUS_A = 8'h02;
   localparam logic [7:0] IRQ_A    = 8'h03;
   localparam logic [7:0] IER_A    = 8'h04;
   localparam logic [7:0] BTR0_A   = 8'h06;
   localparam logic [7:0] BTR1_A   = 8'h07;
   localparam logic [7:0] TXB_BASE = 8'h0A;
   localparam logic [7:0] RXB_BASE = 8'h14;

   localparam int CMD_TX_REQ      = 0;
   localparam int CMD_ABORT       = 1;
   localparam int CMD_RELEASE_RX  = 2;
   localparam int CMD_CLR_OVERRUN = 3;

   typedef enum logic [2:0] {
      IDLE,
      ACCESS,
      RXWAIT,
      ACK,
      HOLD
   } wb_resp_state_e;

endpackage

// File: rtl/can_irq_ctrl.sv
// Interrupt flag register: per-bit set on event pulses, bulk clear on a
// register read, with an active-low masked interrupt output.
// Ports: clk/rst (sync, active-high), evt set pulses, ier mask, clr strobe,
// irq flag value, irq_n = ~|(irq & ier).
module can_irq_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] evt,
   input  logic [7:0] ier,
   input  logic       clr,
   output logic [7:0] irq,
   output logic       irq_n
);

   // An event arriving in the clearing cycle wins over the clear.
   always_ff @(posedge clk) begin
      if (rst)
         irq <= '0;
      else
         irq <= (irq & ~{8{clr}}) | evt;
   end

   assign irq_n = ~|(irq & ier);

endmodule

// File: rtl/can_wb_responder.sv
// Wishbone classic 8-bit slave exposing the CAN controller register file.
// Ports: wb_* bus (sync active-high reset, one-cycle ack, N+2 / N+3 for RX
// window), mode/btr/command/TX-buffer outputs, status/irq/RX-window inputs.
// Optional macro CAN_WB_RESP_ERR_EN adds wb_err_o for unmapped addresses.
module can_wb_responder #(
   parameter int TX_BYTES = 10,
   parameter int RX_BYTES = 10
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [7:0]            wb_adr_i,
   input  logic [7:0]            wb_dat_i,
   output logic [7:0]            wb_dat_o,
   output logic                  wb_ack_o,
`ifdef CAN_WB_RESP_ERR_EN
   output logic                  wb_err_o,
`endif
   output logic                  reset_mode_o,
   output logic [7:0]            btr0_o,
   output logic [7:0]            btr1_o,
   output logic                  cmd_tx_req_o,
   output logic                  cmd_abort_o,
   output logic                  cmd_release_rx_o,
   output logic                  cmd_clr_overrun_o,
   input  logic [7:0]            status_i,
   input  logic [7:0]            irq_evt_i,
   output logic                  irq_on,
   output logic [8*TX_BYTES-1:0] tx_buf_o,
   output logic [3:0]            rx_rd_addr_o,
   input  logic [7:0]            rx_rd_data_i
);
   import can_regs_pkg::*;

   localparam logic [7:0] TXB_END = 8'(TXB_BASE + TX_BYTES);
   localparam logic [7:0] RXB_END = 8'(RXB_BASE + RX_BYTES);

   wb_resp_state_e state, state_nxt;

   logic [7:0] adr_q, dat_q;
   logic       we_q;
   logic       mode_q;
   logic [7:0] ier_q;
   logic [3:0] cmd_q;
   logic [7:0] irq_q;
   logic       irq_clr;
   logic       tx_hit, rx_hit, rx_hit_in;
   logic [7:0] tx_idx;
   logic [7:0] rd_val;

   assign tx_idx    = adr_q - TXB_BASE;
   assign tx_hit    = (adr_q >= TXB_BASE) && (adr_q < TXB_END);
   assign rx_hit    = (adr_q >= RXB_BASE) && (adr_q < RXB_END);
   assign rx_hit_in = (wb_adr_i >= RXB_BASE) && (wb_adr_i < RXB_END);

`ifdef CAN_WB_RESP_ERR_EN
   logic mapped;
   assign mapped = (adr_q inside {MODE_A, CMD_A, STATUS_A, IRQ_A, IER_A, BTR0_A, BTR1_A})
                   || tx_hit || rx_hit;
`endif

   always_comb begin
      rd_val = '0;
      case (adr_q)
         MODE_A:   rd_val = {7'd0, mode_q};
         CMD_A:    rd_val = 8'hFF;
         STATUS_A: rd_val = status_i;
         IRQ_A:    rd_val = irq_q;
         IER_A:    rd_val = ier_q;
         BTR0_A:   rd_val = btr0_o;
         BTR1_A:   rd_val = btr1_o;
         default: begin
            for (int k = 0; k < TX_BYTES; k++)
               if (tx_hit && tx_idx == 8'(k))
                  rd_val = tx_buf_o[8*k +: 8];
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wb_ack_o  = 1'b0;
`ifdef CAN_WB_RESP_ERR_EN
      wb_err_o  = 1'b0;
`endif
      irq_clr   = 1'b0;
      case (state)
         IDLE:   if (wb_cyc_i && wb_stb_i) state_nxt = ACCESS;
         // Cycle drops here are ignored: the access still finishes and acks.
         ACCESS: state_nxt = (rx_hit && !we_q) ? RXWAIT : ACK;
         RXWAIT: state_nxt = ACK;
         ACK: begin
`ifdef CAN_WB_RESP_ERR_EN
            wb_ack_o = mapped;
            wb_err_o = !mapped;
`else
            wb_ack_o = 1'b1;
`endif
            irq_clr   = !we_q && (adr_q == IRQ_A);
            state_nxt = HOLD;
         end
         // A strobe still held after ack must not start a second access.
         HOLD:   if (!(wb_cyc_i && wb_stb_i)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         adr_q        <= '0;
         dat_q        <= '0;
         we_q         <= 1'b0;
         mode_q       <= 1'b1;
         ier_q        <= '0;
         btr0_o       <= '0;
         btr1_o       <= '0;
         cmd_q        <= '0;
         tx_buf_o     <= '0;
         wb_dat_o     <= '0;
         rx_rd_addr_o <= '0;
      end else begin
         cmd_q <= '0;
         case (state)
            IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  adr_q <= wb_adr_i;
                  we_q  <= wb_we_i;
                  dat_q <= wb_dat_i;
                  // Present the RX index during ACCESS so the core's
                  // one-cycle read data is ready in RXWAIT.
                  if (rx_hit_in)
                     rx_rd_addr_o <= 4'(wb_adr_i - RXB_BASE);
               end
            end
            ACCESS: begin
               if (we_q) begin
                  case (adr_q)
                     MODE_A: mode_q <= dat_q[0];
                     CMD_A:  cmd_q  <= dat_q[3:0];
                     IER_A:  ier_q  <= dat_q;
                     BTR0_A: if (mode_q) btr0_o <= dat_q;
                     BTR1_A: if (mode_q) btr1_o <= dat_q;
                     default: begin
                        for (int k = 0; k < TX_BYTES; k++)
                           if (tx_hit && tx_idx == 8'(k))
                              tx_buf_o[8*k +: 8] <= dat_q;
                     end
                  endcase
               end else if (!rx_hit) begin
                  wb_dat_o <= rd_val;
               end
            end
            RXWAIT: wb_dat_o <= rx_rd_data_i;
            default: ;
         endcase
      end
   end

   assign reset_mode_o      = mode_q;
   assign cmd_tx_req_o      = cmd_q[CMD_TX_REQ];
   assign cmd_abort_o       = cmd_q[CMD_ABORT];
   assign cmd_release_rx_o  = cmd_q[CMD_RELEASE_RX];
   assign cmd_clr_overrun_o = cmd_q[CMD_CLR_OVERRUN];

   can_irq_ctrl u_irq (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .evt   (irq_evt_i),
      .ier   (ier_q),
      .clr   (irq_clr),
      .irq   (irq_q),
      .irq_n (irq_on)
   );

endmodule

// File: tb/tb_can_wb_responder.sv
// Self-checking bench for can_wb_responder: directed Wishbone accesses with
// hand-computed expected values, plus a registered RX-window core model.
// Ports: none (top-level bench).
module tb_can_wb_responder;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_we_i  = 1'b0;
   logic [7:0]  wb_adr_i = '0;
   logic [7:0]  wb_dat_i = '0;
   logic [7:0]  wb_dat_o;
   logic        wb_ack_o;
   logic        reset_mode_o;
   logic [7:0]  btr0_o, btr1_o;
   logic        cmd_tx_req_o, cmd_abort_o, cmd_release_rx_o, cmd_clr_overrun_o;
   logic [7:0]  status_i = 8'hA5;
   logic [7:0]  irq_evt_i = '0;
   logic        irq_on;
   logic [79:0] tx_buf_o;
   logic [3:0]  rx_rd_addr_o;
   logic [7:0]  rx_rd_data_i = '0;
   logic        err_sig;

`ifdef CAN_WB_RESP_ERR_EN
   logic wb_err_o;
   assign err_sig = wb_err_o;
`else
   assign err_sig = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int n_ack = 0, n_tx = 0, n_ab = 0, n_rel = 0, n_clr = 0, n_txack = 0;
   logic [7:0] rx_mem [16];

   always #5 wb_clk_i = ~wb_clk_i;

   can_wb_responder dut (
      .wb_clk_i          (wb_clk_i),
      .wb_rst_i          (wb_rst_i),
      .wb_cyc_i          (wb_cyc_i),
      .wb_stb_i          (wb_stb_i),
      .wb_we_i           (wb_we_i),
      .wb_adr_i          (wb_adr_i),
      .wb_dat_i          (wb_dat_i),
      .wb_dat_o          (wb_dat_o),
      .wb_ack_o          (wb_ack_o),
`ifdef CAN_WB_RESP_ERR_EN
      .wb_err_o          (wb_err_o),
`endif
      .reset_mode_o      (reset_mode_o),
      .btr0_o            (btr0_o),
      .btr1_o            (btr1_o),
      .cmd_tx_req_o      (cmd_tx_req_o),
      .cmd_abort_o       (cmd_abort_o),
      .cmd_release_rx_o  (cmd_release_rx_o),
      .cmd_clr_overrun_o (cmd_clr_overrun_o),
      .status_i          (status_i),
      .irq_evt_i         (irq_evt_i),
      .irq_on            (irq_on),
      .tx_buf_o          (tx_buf_o),
      .rx_rd_addr_o      (rx_rd_addr_o),
      .rx_rd_data_i      (rx_rd_data_i)
   );

   // RX core model: registered read, data one cycle after the address.
   always @(posedge wb_clk_i) rx_rd_data_i <= rx_mem[rx_rd_addr_o];

   always @(negedge wb_clk_i) begin
      if (wb_ack_o)                     n_ack++;
      if (cmd_tx_req_o)                 n_tx++;
      if (cmd_abort_o)                  n_ab++;
      if (cmd_release_rx_o)             n_rel++;
      if (cmd_clr_overrun_o)            n_clr++;
      if (cmd_tx_req_o && wb_ack_o)     n_txack++;
   end

   // One bus access; lat counts edges from the strobe-sampling edge (1 = that
   // edge) to the termination, or -1 on timeout.
   task automatic bus(input logic [7:0] adr, input logic we, input logic [7:0] dat,
                      input int extra, output logic [7:0] rdata, output int lat,
                      output logic err);
      bit done = 0;
      @(negedge wb_clk_i);
      wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat;
      lat = -1; err = 0; rdata = 'x;
      for (int n = 1; n <= 20 && !done; n++) begin
         @(posedge wb_clk_i); #1;
         if (wb_ack_o || err_sig) begin
            lat = n; err = err_sig; rdata = wb_dat_o; done = 1;
         end
      end
      repeat (extra) @(posedge wb_clk_i);
      #1;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      repeat (3) @(posedge wb_clk_i);
   endtask

   task automatic test_reset;
      logic [7:0] rd; int lat; logic er;
      wb_rst_i = 1;
      repeat (3) @(posedge wb_clk_i);
      @(negedge wb_clk_i) wb_rst_i = 0;
      @(negedge wb_clk_i);
      checks++; if (reset_mode_o !== 1'b1) begin errors++; $display("FAIL reset_mode got %b want 1", reset_mode_o); end
      checks++; if (irq_on !== 1'b1) begin errors++; $display("FAIL reset_irq_on got %b want 1", irq_on); end
      checks++; if (wb_ack_o !== 1'b0 || err_sig !== 1'b0) begin errors++; $display("FAIL reset_ack got %b/%b want 0/0", wb_ack_o, err_sig); end
      checks++; if (wb_dat_o !== 8'h00 || btr0_o !== 8'h00 || btr1_o !== 8'h00) begin errors++; $display("FAIL reset_regs got %h %h %h want 00", wb_dat_o, btr0_o, btr1_o); end
      checks++; if (tx_buf_o !== 80'h0 || rx_rd_addr_o !== 4'h0) begin errors++; $display("FAIL reset_buf got %h %h want 0", tx_buf_o, rx_rd_addr_o); end
      checks++; if ({cmd_tx_req_o, cmd_abort_o, cmd_release_rx_o, cmd_clr_overrun_o} !== 4'b0) begin errors++; $display("FAIL reset_cmd got nonzero want 0"); end
      bus(8'h00, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h01 || lat !== 2) begin errors++; $display("FAIL rd_mode got %h lat %0d want 01 lat 2", rd, lat); end
      bus(8'h07, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h00 || lat !== 2) begin errors++; $display("FAIL rd_btr1 got %h lat %0d want 00 lat 2", rd, lat); end
      bus(8'h02, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL rd_status got %h want a5", rd); end
      checks++; if (irq_on !== 1'b1) begin errors++; $display("FAIL idle_irq_on got %b want 1", irq_on); end
   endtask

   task automatic test_btr;
      logic [7:0] rd; int lat; logic er;
      bus(8'h06, 1, 8'h5A, 0, rd, lat, er);
      checks++; if (btr0_o !== 8'h5A || lat !== 2) begin errors++; $display("FAIL btr0_wr got %h lat %0d want 5a lat 2", btr0_o, lat); end
      bus(8'h00, 1, 8'h00, 0, rd, lat, er);
      checks++; if (reset_mode_o !== 1'b0) begin errors++; $display("FAIL mode_clr got %b want 0", reset_mode_o); end
      bus(8'h06, 1, 8'hFF, 0, rd, lat, er);
      checks++; if (btr0_o !== 8'h5A || lat !== 2) begin errors++; $display("FAIL btr0_locked got %h lat %0d want 5a lat 2", btr0_o, lat); end
      bus(8'h07, 1, 8'h33, 0, rd, lat, er);
      checks++; if (btr1_o !== 8'h00) begin errors++; $display("FAIL btr1_locked got %h want 00", btr1_o); end
      bus(8'h00, 1, 8'hFF, 0, rd, lat, er);
      bus(8'h00, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h01) begin errors++; $display("FAIL mode_bit0_only got %h want 01", rd); end
      bus(8'h07, 1, 8'h33, 0, rd, lat, er);
      checks++; if (btr1_o !== 8'h33) begin errors++; $display("FAIL btr1_wr got %h want 33", btr1_o); end
   endtask

   task automatic test_cmd;
      logic [7:0] rd; int lat; logic er;
      int t0, a0, r0, c0, k0;
      t0 = n_tx; a0 = n_ab; r0 = n_rel; c0 = n_clr; k0 = n_txack;
      bus(8'h01, 1, 8'h01, 0, rd, lat, er);
      checks++; if (n_tx - t0 !== 1) begin errors++; $display("FAIL cmd_tx_pulse got %0d cycles want 1", n_tx - t0); end
      checks++; if (n_txack - k0 !== 1) begin errors++; $display("FAIL cmd_tx_timing got %0d want 1", n_txack - k0); end
      checks++; if (n_ab - a0 + n_rel - r0 + n_clr - c0 !== 0) begin errors++; $display("FAIL cmd_others got %0d want 0", n_ab - a0 + n_rel - r0 + n_clr - c0); end
      t0 = n_tx;
      bus(8'h01, 0, 8'h0F, 0, rd, lat, er);
      checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL cmd_read got %h want ff", rd); end
      checks++; if (n_tx - t0 !== 0) begin errors++; $display("FAIL cmd_on_read got %0d want 0", n_tx - t0); end
      t0 = n_tx; a0 = n_ab; r0 = n_rel; c0 = n_clr;
      bus(8'h01, 1, 8'h0C, 0, rd, lat, er);
      checks++; if ({n_tx - t0, n_ab - a0, n_rel - r0, n_clr - c0} !== {32'd0, 32'd0, 32'd1, 32'd1})
         begin errors++; $display("FAIL cmd_0c got %0d%0d%0d%0d want 0011", n_tx - t0, n_ab - a0, n_rel - r0, n_clr - c0); end
   endtask

   task automatic test_irq;
      logic [7:0] rd, rd2; int lat; logic er;
      bus(8'h04, 1, 8'h04, 0, rd, lat, er);
      @(negedge wb_clk_i) irq_evt_i = 8'h02;
      @(negedge wb_clk_i) irq_evt_i = 8'h00;
      checks++; if (irq_on !== 1'b1) begin errors++; $display("FAIL irq_masked got %b want 1", irq_on); end
      @(negedge wb_clk_i) irq_evt_i = 8'h04;
      @(negedge wb_clk_i) irq_evt_i = 8'h00;
      checks++; if (irq_on !== 1'b0) begin errors++; $display("FAIL irq_assert got %b want 0", irq_on); end
      bus(8'h03, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h06) begin errors++; $display("FAIL irq_read got %h want 06", rd); end
      checks++; if (irq_on !== 1'b1) begin errors++; $display("FAIL irq_cleared got %b want 1", irq_on); end
      bus(8'h03, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL irq_reread got %h want 00", rd); end
      // Event coinciding with the clearing ack cycle.
      @(negedge wb_clk_i) irq_evt_i = 8'h04;
      @(negedge wb_clk_i) irq_evt_i = 8'h00;
      wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = 8'h03; wb_we_i = 0;
      @(posedge wb_clk_i); @(posedge wb_clk_i); #1;
      checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL irq_race_ack got %b want 1", wb_ack_o); end
      rd2 = wb_dat_o;
      irq_evt_i = 8'h04;
      @(posedge wb_clk_i); #1;
      irq_evt_i = 8'h00; wb_cyc_i = 0; wb_stb_i = 0;
      repeat (3) @(posedge wb_clk_i);
      #1;
      checks++; if (rd2 !== 8'h04 || irq_on !== 1'b0) begin errors++; $display("FAIL irq_race got %h/%b want 04/0", rd2, irq_on); end
      bus(8'h03, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h04 || irq_on !== 1'b1) begin errors++; $display("FAIL irq_race_clr got %h/%b want 04/1", rd, irq_on); end
   endtask

   task automatic test_txbuf;
      logic [7:0] rd; int lat; logic er;
      bus(8'h0A, 1, 8'h11, 0, rd, lat, er);
      bus(8'h13, 1, 8'h99, 0, rd, lat, er);
      bus(8'h13, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h99 || lat !== 2) begin errors++; $display("FAIL tx_last got %h lat %0d want 99 lat 2", rd, lat); end
      checks++; if (tx_buf_o !== {8'h99, 64'h0, 8'h11}) begin errors++; $display("FAIL tx_buf got %h want 99..11", tx_buf_o); end
      bus(8'h14, 1, 8'hEE, 0, rd, lat, er);
      checks++; if (lat !== 2 || tx_buf_o !== {8'h99, 64'h0, 8'h11}) begin errors++; $display("FAIL rx_write_drop got lat %0d buf %h want 2", lat, tx_buf_o); end
   endtask

   task automatic test_rx;
      logic [7:0] rd; int lat; logic er;
      bus(8'h16, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'hC3 || lat !== 3 || rx_rd_addr_o !== 4'd2) begin errors++; $display("FAIL rx_idx2 got %h lat %0d adr %0d want c3 lat 3 adr 2", rd, lat, rx_rd_addr_o); end
      bus(8'h1D, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h59 || lat !== 3 || rx_rd_addr_o !== 4'd9) begin errors++; $display("FAIL rx_idx9 got %h lat %0d adr %0d want 59 lat 3 adr 9", rd, lat, rx_rd_addr_o); end
   endtask

   task automatic test_unmapped;
      logic [7:0] rd; int lat; logic er; int a0;
      bus(8'h05, 1, 8'h77, 0, rd, lat, er);
      foreach (rx_mem[i]) ;
      a0 = n_ack;
      bus(8'hF0, 0, 8'h00, 0, rd, lat, er);
`ifdef CAN_WB_RESP_ERR_EN
      checks++; if (er !== 1'b1 || lat !== 2 || n_ack - a0 !== 0) begin errors++; $display("FAIL unmapped_err got err %b lat %0d acks %0d want 1 2 0", er, lat, n_ack - a0); end
`else
      checks++; if (er !== 1'b0 || lat !== 2 || n_ack - a0 !== 1 || rd !== 8'h00) begin errors++; $display("FAIL unmapped_ack got %h err %b lat %0d acks %0d want 00 0 2 1", rd, er, lat, n_ack - a0); end
`endif
      bus(8'h05, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h00 || lat !== 2) begin errors++; $display("FAIL unmapped_05 got %h lat %0d want 00 lat 2", rd, lat); end
      bus(8'h1E, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h00 || lat !== 2) begin errors++; $display("FAIL past_rx got %h lat %0d want 00 lat 2", rd, lat); end
   endtask

   task automatic test_hold;
      logic [7:0] rd; int lat; logic er; int a0;
      a0 = n_ack;
      bus(8'h04, 0, 8'h00, 2, rd, lat, er);
      checks++; if (n_ack - a0 !== 1 || lat !== 2 || rd !== 8'h04) begin errors++; $display("FAIL hold_single_ack got acks %0d lat %0d rd %h want 1 2 04", n_ack - a0, lat, rd); end
   endtask

   task automatic test_drop_cyc;
      logic [7:0] rd; int lat; logic er; int a0;
      a0 = n_ack;
      @(negedge wb_clk_i);
      wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = 8'h04; wb_we_i = 1; wb_dat_i = 8'h5C;
      @(posedge wb_clk_i); #1;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      repeat (4) @(posedge wb_clk_i);
      checks++; if (n_ack - a0 !== 1) begin errors++; $display("FAIL drop_cyc_ack got %0d want 1", n_ack - a0); end
      bus(8'h04, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h5C) begin errors++; $display("FAIL drop_cyc_commit got %h want 5c", rd); end
   endtask

   task automatic test_mid_reset;
      logic [7:0] rd; int lat; logic er; int a0;
      bus(8'h00, 1, 8'h00, 0, rd, lat, er);
      a0 = n_ack;
      @(negedge wb_clk_i);
      wb_cyc_i = 1; wb_stb_i = 1; wb_adr_i = 8'h04; wb_we_i = 0;
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1;
      @(posedge wb_clk_i); #1;
      wb_rst_i = 0; wb_cyc_i = 0; wb_stb_i = 0;
      repeat (4) @(posedge wb_clk_i);
      #1;
      checks++; if (n_ack - a0 !== 0 || reset_mode_o !== 1'b1) begin errors++; $display("FAIL mid_reset got acks %0d mode %b want 0 1", n_ack - a0, reset_mode_o); end
      bus(8'h04, 0, 8'h00, 0, rd, lat, er);
      checks++; if (rd !== 8'h00 || lat !== 2) begin errors++; $display("FAIL post_reset_ier got %h lat %0d want 00 lat 2", rd, lat); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rx_mem[i] = 8'h50 + 8'(i);
      rx_mem[2] = 8'hC3;
      test_reset;
      test_btr;
      test_cmd;
      test_irq;
      test_txbuf;
      test_rx;
      test_unmapped;
      test_hold;
      test_drop_cyc;
      test_mid_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
